fp_wb_buffer: RTL

- Writeback stage directly downstream of fp_rnd.
- Captures each rounded result, its status flags and an issue tag into a small FIFO, then presents them to the register-file writeback port using a valid/ready handshake.
- Keeps the sticky accrued exception flags (fflags) that the CSR logic reads.
- Decouples multi-cycle units (fp_div, fp_sqrt) from writeback stalls.

---
 rtl/fp_pkg.sv | 65 ++++++
 rtl/fp_wb_fifo.sv | 60 ++++++
 rtl/fp_wb_buffer.sv | 84 ++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Floating-point shared package: formats, status flags, width helpers,
// the writeback entry bundle and the canonical quiet-NaN constant.
package fp_pkg;

    typedef enum logic [1:0] {
        FP32,
        FP64,
        FP16,
        FP16ALT
    } fp_format_e;

    // Exception flags in fflags order: NV, DZ, OF, UF, NX.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP64:    return 64;
            FP16:    return 16;
            FP16ALT: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    localparam int unsigned WB_FP_WIDTH  = fp_width(FP32);
    localparam int unsigned WB_TAG_WIDTH = 5;

    typedef struct packed {
        logic [WB_FP_WIDTH-1:0]  result;
        status_t                 flags;
        logic [WB_TAG_WIDTH-1:0] tag;
    } wb_entry_t;

    // Sign 0, exponent all ones, mantissa MSB set, rest zero,
    // right-aligned in 64 bits.
    function automatic logic [63:0] canon_nan(fp_format_e fmt);
        logic [63:0] ones;
        ones = (64'd1 << (exp_bits(fmt) + 1)) - 64'd1;
        return ones << (man_bits(fmt) - 1);
    endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Generic DEPTH x WIDTH FIFO with wrap-bit pointers and occupancy count.
// Ports: clk_i, reset_i, valid_i/ready_o/data_i (in), valid_o/ready_i/data_o (out), count_o.
module fp_wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, push, pop;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // Both depend on pointer state only; no path from ready_i.
    assign ready_o = !full;
    assign valid_o = !empty;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    assign wr_d = push ? wr_q + 1'b1 : wr_q;
    assign rd_d = pop  ? rd_q + 1'b1 : rd_q;

    assign count_o = wr_q - rd_q;

    // Gated so the output reads zero while storage is uninitialised.
    assign data_o = valid_o ? mem_q[rd_q[AW-1:0]] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fp_wb_buffer.sv
// FP writeback buffer: queues rounded results/flags/tags for the register file
// and keeps the sticky fflags. Optional macro FP_WB_CANON_NAN_EN canonicalises NaNs.
// Ports: clk_i, reset_i, upstream valid_i/ready_o/result_i/flags_i/tag_i,
// writeback valid_o/ready_i/result_o/flags_o/tag_o, count_o, fflags_o, fflags_clr_i.
module fp_wb_buffer
    import fp_pkg::*;
#(
    parameter  fp_format_e  FP_FORMAT = FP32,
    parameter  int unsigned DEPTH     = 2,
    parameter  int unsigned TAG_WIDTH = 5,
    localparam int unsigned FP_WIDTH  = fp_width(FP_FORMAT)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [FP_WIDTH-1:0]    result_i,
    input  status_t                flags_i,
    input  logic [TAG_WIDTH-1:0]   tag_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [FP_WIDTH-1:0]    result_o,
    output status_t                flags_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic [$clog2(DEPTH):0] count_o,
    output status_t                fflags_o,
    input  logic                   fflags_clr_i
);

    localparam int unsigned EW = FP_WIDTH + 5 + TAG_WIDTH;

    logic [FP_WIDTH-1:0] res_st;
    logic [EW-1:0]       ent_in, ent_out;
    status_t             fflags_q, fflags_d;
    logic                pop;

`ifdef FP_WB_CANON_NAN_EN
    localparam int unsigned EXP  = exp_bits(FP_FORMAT);
    localparam int unsigned MAN  = man_bits(FP_FORMAT);
    localparam logic [63:0] CNAN = canon_nan(FP_FORMAT);

    logic is_nan;
    assign is_nan = (&result_i[FP_WIDTH-2 -: EXP]) &&
                    (|result_i[MAN-1:0]);
    assign res_st = is_nan ? CNAN[FP_WIDTH-1:0] : result_i;
`else
    assign res_st = result_i;
`endif

    assign ent_in = {res_st, flags_i, tag_i};
    assign {result_o, flags_o, tag_o} = ent_out;

    fp_wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (ent_in),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (ent_out),
        .count_o (count_o)
    );

    assign pop = valid_o & ready_i;

    // Accrue at commit; a same-cycle clear still keeps the popped flags.
    assign fflags_d = (fflags_clr_i ? status_t'(5'b0) : fflags_q) |
                      (pop ? flags_o : status_t'(5'b0));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags_o = fflags_q;

endmodule
